// File: rtl/calc_entry.sv
// rtl/calc_entry.sv - calculator key-entry FSM: digit accumulation, operator latch, add/sub with overflow
module calc_entry #(
  parameter int DIGITS = 4,
  parameter int RW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_press,
  input  logic          is_num,
  input  logic          is_op,
  input  logic          is_eq,
  input  logic [3:0]    num_val,
  input  logic [1:0]    op_val,
  output logic [RW-1:0] disp_val,
  output logic          result_valid,
  output logic          ovf,
  output logic          key_ack,
  output logic [1:0]    state
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENT_A   = 2'd0,
    OP_WAIT = 2'd1,
    ENT_B   = 2'd2,
    RESULT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] a_q, a_d;
  logic [RW-1:0] b_q, b_d;
  logic          op_sub_q, op_sub_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;
  logic [RW-1:0] disp_q, disp_d;
  logic          rv_q, rv_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;

  logic          accept;
  logic          op_valid;
  logic          num_valid;
  logic          cnt_full;
  logic [RW-1:0] num_ext;
  logic [RW-1:0] a_acc;
  logic [RW-1:0] b_acc;
  logic [RW-1:0] calc_res;
  logic          calc_ovf;

  // Key-event qualification and datapath helpers shared by all states
  always_comb begin
    accept    = btn_press & ~press_q;
    op_valid  = (op_val == 2'd1) || (op_val == 2'd2);
    num_valid = (num_val <= 4'd9);
    cnt_full  = (cnt_q == CNT_MAX);
    num_ext   = RW'(num_val);
    a_acc     = a_q * RW'(10) + num_ext;
    b_acc     = b_q * RW'(10) + num_ext;
    calc_res  = op_sub_q ? (a_q - b_q) : (a_q + b_q);
    if (op_sub_q) begin
      calc_ovf = (a_q[RW-1] != b_q[RW-1]) && (calc_res[RW-1] != a_q[RW-1]);
    end else begin
      calc_ovf = (a_q[RW-1] == b_q[RW-1]) && (calc_res[RW-1] != a_q[RW-1]);
    end
  end

  // Next-state and register updates for one accepted key; eq beats op beats digit
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_sub_d = op_sub_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    ack_d    = 1'b0;
    if (accept) begin
      ack_d = 1'b1;
      if (is_eq) begin
        if (state_q == ENT_B) begin
          a_d     = calc_res;
          ovf_d   = ovf_q | calc_ovf;
          rv_d    = 1'b1;
          state_d = RESULT;
        end
      end else if (is_op) begin
        if (op_valid) begin
          op_sub_d = (op_val == 2'd2);
          state_d  = OP_WAIT;
          if (state_q == ENT_B) begin
            a_d   = calc_res;
            ovf_d = ovf_q | calc_ovf;
            rv_d  = 1'b1;
            b_d   = '0;
          end
        end
      end else if (is_num) begin
        if (num_valid) begin
          unique case (state_q)
            ENT_A: begin
              if (!cnt_full) begin
                a_d   = a_acc;
                cnt_d = cnt_q + CW'(1);
              end
            end
            OP_WAIT: begin
              b_d     = num_ext;
              cnt_d   = CW'(1);
              state_d = ENT_B;
            end
            ENT_B: begin
              if (!cnt_full) begin
                b_d   = b_acc;
                cnt_d = cnt_q + CW'(1);
              end
            end
            RESULT: begin
              a_d     = num_ext;
              cnt_d   = CW'(1);
              ovf_d   = 1'b0;
              state_d = ENT_A;
            end
            default: state_d = ENT_A;
          endcase
        end
      end
    end
    disp_d = (state_d == ENT_B) ? b_d : a_d;
  end

  // State and datapath registers; press_q resets high so a held key is not taken at release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ENT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_sub_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b1;
      disp_q   <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_sub_q <= op_sub_d;
      cnt_q    <= cnt_d;
      press_q  <= btn_press;
      disp_q   <= disp_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
    end
  end

  assign disp_val     = disp_q;
  assign result_valid = rv_q;
  assign ovf          = ovf_q;
  assign key_ack      = ack_q;
  assign state        = state_q;

endmodule
